// File: rtl/cpu_frame_driver.sv
// cpu_frame_driver: serialises one {A,X,OP} operation onto the core's start/bit pins and captures the result and flags
// Optional feature macro CPU_FRAME_PARITY_EN: appends an odd-parity bit to the frame and adds parity_bit_o.
module cpu_frame_driver #(
    parameter int BIT_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_a_i,
    input  logic [7:0] req_x_i,
    input  logic [3:0] req_op_i,
    output logic       fsm_start_o,
    output logic       fsm_bit_o,
    input  logic [7:0] core_result_i,
    input  logic [3:0] core_flags_i,
    output logic       res_valid_o,
    output logic [7:0] res_data_o,
    output logic [3:0] res_flags_o,
`ifdef CPU_FRAME_PARITY_EN
    output logic       parity_bit_o,
`endif
    output logic       busy_o
);
`ifdef CPU_FRAME_PARITY_EN
    localparam int FW = 21;
`else
    localparam int FW = 20;
`endif
    localparam logic [4:0] BIT_LAST    = 5'(FW - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(BIT_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_SETTLE, S_CAPTURE} state_t;

    state_t          r_state, w_next;
    logic [FW-1:0]   r_frame, w_frame_nxt, w_frame_load;
    logic [4:0]      r_bit_cnt;
    logic [3:0]      r_hold;
    logic [7:0]      r_settle;
    logic [19:0]     w_payload;
    logic            w_accept, w_hold_end, w_last_bit;

    assign w_payload  = {req_a_i, req_x_i, req_op_i};
`ifdef CPU_FRAME_PARITY_EN
    assign w_frame_load = {w_payload, ~^w_payload};
`else
    assign w_frame_load = w_payload;
`endif
    assign w_accept   = (r_state == S_IDLE) && req_valid_i && req_ready_o;
    assign w_hold_end = (r_state == S_SHIFT) && (r_hold == HOLD_LAST);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and next frame contents
    always_comb begin
        w_next      = r_state;
        w_frame_nxt = w_accept ? w_frame_load : w_hold_end ? {r_frame[FW-2:0], 1'b0} : r_frame;
        case (r_state)
            S_IDLE:    w_next = w_accept ? S_START : S_IDLE;
            S_START:   w_next = S_SHIFT;
            S_SHIFT:   w_next = (w_hold_end && w_last_bit) ? S_SETTLE : S_SHIFT;
            S_SETTLE:  w_next = (r_settle == SETTLE_LAST) ? S_CAPTURE : S_SETTLE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs derived from the upcoming state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_settle    <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            fsm_start_o <= 1'b0;
            fsm_bit_o   <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_flags_o <= '0;
`ifdef CPU_FRAME_PARITY_EN
            parity_bit_o <= 1'b0;
`endif
        end else begin
            r_frame     <= w_frame_nxt;
            r_hold      <= (r_state == S_SHIFT && !w_hold_end) ? r_hold + 4'd1 : 4'd0;
            r_bit_cnt   <= (r_state != S_SHIFT) ? 5'd0 : w_hold_end ? (w_last_bit ? 5'd0 : r_bit_cnt + 5'd1) : r_bit_cnt;
            r_settle    <= (r_state == S_SETTLE && w_next == S_SETTLE) ? r_settle + 8'd1 : 8'd0;
            req_ready_o <= (w_next == S_IDLE);
            busy_o      <= (w_next != S_IDLE);
            fsm_start_o <= (w_next == S_START);
            fsm_bit_o   <= (w_next == S_SHIFT) && w_frame_nxt[FW-1];
            res_valid_o <= (r_state == S_CAPTURE);
            if (r_state == S_CAPTURE) begin
                res_data_o  <= core_result_i;
                res_flags_o <= core_flags_i;
            end
`ifdef CPU_FRAME_PARITY_EN
            if (w_accept) parity_bit_o <= w_frame_load[0];
`endif
        end
    end
endmodule

// File: tb/tb_cpu_frame_driver.sv
// tb_cpu_frame_driver: directed bench with a result scoreboard for two parameterisations of cpu_frame_driver
module tb_cpu_frame_driver;
`ifdef CPU_FRAME_PARITY_EN
    localparam int FW = 21;
`else
    localparam int FW = 20;
`endif
    localparam int LAT = 3 + FW + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [7:0]       req_a, req_x;
    logic [3:0]       req_op;
    logic [7:0]       core_result;
    logic [3:0]       core_flags;
    logic [1:0]       ready, start, bitw, valid, busy, par;
    logic [1:0][7:0]  data;
    logic [1:0][3:0]  flags;
    logic [11:0]      sb[$];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    cpu_frame_driver #(.BIT_CYCLES(1), .SETTLE_CYCLES(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
        .req_a_i(req_a), .req_x_i(req_x), .req_op_i(req_op),
        .fsm_start_o(start[0]), .fsm_bit_o(bitw[0]),
        .core_result_i(core_result), .core_flags_i(core_flags),
        .res_valid_o(valid[0]), .res_data_o(data[0]), .res_flags_o(flags[0]),
`ifdef CPU_FRAME_PARITY_EN
        .parity_bit_o(par[0]),
`endif
        .busy_o(busy[0])
    );

    cpu_frame_driver #(.BIT_CYCLES(3), .SETTLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
        .req_a_i(req_a), .req_x_i(req_x), .req_op_i(req_op),
        .fsm_start_o(start[1]), .fsm_bit_o(bitw[1]),
        .core_result_i(core_result), .core_flags_i(core_flags),
        .res_valid_o(valid[1]), .res_data_o(data[1]), .res_flags_o(flags[1]),
`ifdef CPU_FRAME_PARITY_EN
        .parity_bit_o(par[1]),
`endif
        .busy_o(busy[1])
    );

`ifndef CPU_FRAME_PARITY_EN
    assign par = 2'b00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_ready"}, 32'(ready[k]), 1);
        chk({tag, "_busy"},  32'(busy[k]), 0);
        chk({tag, "_start"}, 32'(start[k]), 0);
        chk({tag, "_bit"},   32'(bitw[k]), 0);
        chk({tag, "_valid"}, 32'(valid[k]), 0);
    endtask

    task automatic pop_cmp(input int k, input string tag);
        logic [11:0] e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"},  32'(data[k]), 32'(e[11:4]));
            chk({tag, "_flags"}, 32'(flags[k]), 32'(e[3:0]));
        end
    endtask

    task automatic wait_result(input int k, input string tag);
        int t = 0;
        while (!valid[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid_seen"}, 32'(valid[k]), 1);
        pop_cmp(k, tag);
    endtask

    task automatic drive_req(input int k, input logic [7:0] a, input logic [7:0] x, input logic [3:0] op);
        req_valid[k] = 1'b1;
        req_a = a;
        req_x = x;
        req_op = op;
    endtask

    task automatic run_frame(input int k, input logic [7:0] a, input logic [7:0] x, input logic [3:0] op,
                             input logic [7:0] res, input logic [3:0] fl);
        int bc = (k == 0) ? 1 : 3;
        int sc = (k == 0) ? 4 : 1;
        int t = 0;
        logic [19:0] pl;
        logic [20:0] fr;
        pl = {a, x, op};
        fr = (FW == 21) ? {pl, ~^pl} : {1'b0, pl};
        while (!ready[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_req", 32'(ready[k]), 1);
        drive_req(k, a, x, op);
        core_result = res;
        core_flags = fl;
        sb.push_back({res, fl});
        @(negedge clk);
        req_valid[k] = 1'b0;
        chk("start_cycle1", 32'(start[k]), 1);
        chk("busy_cycle1", 32'(busy[k]), 1);
        chk("ready_cycle1", 32'(ready[k]), 0);
        chk("bit_cycle1", 32'(bitw[k]), 0);
        for (int i = 0; i < FW; i++) begin
            for (int h = 0; h < bc; h++) begin
                @(negedge clk);
                chk($sformatf("k%0d_bit%0d_h%0d", k, i, h), 32'(bitw[k]), 32'(fr[FW-1-i]));
                if (i == 0 && h == 0) chk("start_one_cycle", 32'(start[k]), 0);
            end
        end
        for (int s = 0; s < sc; s++) begin
            @(negedge clk);
            chk("settle_bit", 32'(bitw[k]), 0);
            chk("settle_valid", 32'(valid[k]), 0);
        end
        @(negedge clk);
        chk("capture_valid", 32'(valid[k]), 0);
        chk("capture_busy", 32'(busy[k]), 1);
        @(negedge clk);
        chk("res_valid", 32'(valid[k]), 1);
        chk("ready_at_valid", 32'(ready[k]), 1);
        pop_cmp(k, "frame");
`ifdef CPU_FRAME_PARITY_EN
        chk("parity_bit", 32'(par[k]), 32'(fr[0]));
`endif
        @(negedge clk);
        chk("valid_pulse", 32'(valid[k]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_a = '0;
        req_x = '0;
        req_op = '0;
        core_result = '0;
        core_flags = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "rst0");
        chk_idle(1, "rst1");
        chk("rst_data", 32'(data[0]), 0);
        chk("rst_flags", 32'(flags[0]), 0);
        chk("rst_par", 32'(par[0]), 0);
        @(negedge clk);

        run_frame(0, 8'hA5, 8'h3C, 4'h1, 8'hE1, 4'h8);

        drive_req(0, 8'hA5, 8'h3C, 4'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_bit7", 32'(bitw[0]), 1);
        chk("mid_busy", 32'(busy[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle(0, "midrst");
        chk("midrst_data", 32'(data[0]), 0);
        chk("midrst_flags", 32'(flags[0]), 0);
        repeat (3) @(negedge clk);
        chk_idle(0, "midrst_stay");

        run_frame(1, 8'hFF, 8'h00, 4'hF, 8'h7E, 4'h5);

        drive_req(0, 8'h12, 8'h34, 4'h6);
        core_result = 8'h5A;
        core_flags = 4'h3;
        sb.push_back({8'h5A, 4'h3});
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 1'b0;
            if (c == 5) drive_req(0, 8'h9C, 8'h01, 4'hA);
            if (c >= 5 && c < LAT) chk($sformatf("b2b_ready_c%0d", c), 32'(ready[0]), 0);
            if (c == LAT) begin
                chk("b2b_ready_at_valid", 32'(ready[0]), 1);
                chk("b2b_valid", 32'(valid[0]), 1);
                pop_cmp(0, "b2b_first");
                core_result = 8'hC3;
                core_flags = 4'hF;
                sb.push_back({8'hC3, 4'hF});
            end
            if (c == LAT + 1) begin
                chk("b2b_second_start", 32'(start[0]), 1);
                chk("b2b_valid_drop", 32'(valid[0]), 0);
                req_valid[0] = 1'b0;
            end
        end
        wait_result(0, "b2b_second");
        @(negedge clk);

        drive_req(0, 8'h55, 8'hAA, 4'h2);
        core_result = 8'h10;
        core_flags = 4'h1;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 1'b0;
            if (c == FW + 3) begin
                core_result = 8'h20;
                sb.push_back({8'h20, 4'h1});
            end
        end
        @(negedge clk);
        chk("settle_chg_valid", 32'(valid[0]), 1);
        pop_cmp(0, "settle_chg");
        core_result = 8'h30;
        repeat (3) @(negedge clk);
        chk("hold_after_capture", 32'(data[0]), 8'h20);

        run_frame(0, 8'h01, 8'h00, 4'h0, 8'h01, 4'h0);
        run_frame(0, 8'h03, 8'h00, 4'h0, 8'h00, 4'h2);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
